// File: rtl/ex_redirect.sv
`default_nettype none
// ============================================================================
//  Module   : ex_redirect
//  Purpose  : EX-stage control-transfer resolver and front-end redirect
//             controller. Resolves B / JAL / JALR held in ID/EX, compares the
//             real next PC with the predicted one, raises a flush plus a held
//             redirect toward IF on a mispredict, pulses a predictor update
//             and keeps saturating resolved / mispredict counters.
//  Ports    : clk, rst (async, active-low)
//             ex_t/ex_st/ex_n1/ex_n2/ex_nn/ex_pc/ex_ppc : decoded EX fields
//             stl_mm : memory stall, freezes the block
//             rd_ack : IF accepted rd_pc
//             next_invalid, rd_pce, rd_pc : flush + redirect outputs
//             bp_we, bp_pc, bp_tkn, bp_tgt : predictor update
//             br_cnt, mis_cnt : saturating statistics
//  Revision : 1.0 - initial release
// ============================================================================
module ex_redirect #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       ex_t,
  input  logic [2:0]       ex_st,
  input  logic [31:0]      ex_n1,
  input  logic [31:0]      ex_n2,
  input  logic [31:0]      ex_nn,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_ppc,
  input  logic             stl_mm,
  input  logic             rd_ack,
  output logic             next_invalid,
  output logic             rd_pce,
  output logic [31:0]      rd_pc,
  output logic             bp_we,
  output logic [31:0]      bp_pc,
  output logic             bp_tkn,
  output logic [31:0]      bp_tgt,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mis_cnt
);

  localparam logic [6:0] c_OP_B    = 7'h63;
  localparam logic [6:0] c_OP_JAL  = 7'h6F;
  localparam logic [6:0] c_OP_JALR = 7'h67;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic             next_invalid_q, next_invalid_d;
  logic             rd_pce_q, rd_pce_d;
  logic [31:0]      rd_pc_q, rd_pc_d;
  logic             bp_we_q, bp_we_d;
  logic [31:0]      bp_pc_q, bp_pc_d;
  logic             bp_tkn_q, bp_tkn_d;
  logic [31:0]      bp_tgt_q, bp_tgt_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  // ---------------------------------------------------------------- resolve
  logic        w_is_b, w_is_jal, w_is_jalr, w_br_ok, w_is_ctl;
  logic        w_cond, w_taken, w_mis;
  logic [31:0] w_sum_pc, w_sum_rs, w_tgt, w_actual;

  always_comb begin
    w_is_b    = (ex_t == c_OP_B);
    w_is_jal  = (ex_t == c_OP_JAL);
    w_is_jalr = (ex_t == c_OP_JALR);
    // funct3 010/011 are not defined branches
    w_br_ok   = w_is_b && (ex_st[2:1] != 2'b01);
    w_is_ctl  = w_br_ok || w_is_jal || w_is_jalr;

    w_cond = 1'b0;
    case (ex_st)
      3'b000:  w_cond = (ex_n1 == ex_n2);
      3'b001:  w_cond = (ex_n1 != ex_n2);
      3'b100:  w_cond = ($signed(ex_n1) <  $signed(ex_n2));
      3'b101:  w_cond = ($signed(ex_n1) >= $signed(ex_n2));
      3'b110:  w_cond = (ex_n1 <  ex_n2);
      3'b111:  w_cond = (ex_n1 >= ex_n2);
      default: w_cond = 1'b0;
    endcase

    w_taken  = w_is_jal || w_is_jalr || (w_br_ok && w_cond);
    w_sum_pc = ex_pc + ex_nn;
    w_sum_rs = ex_n1 + ex_nn;
    // JALR clears bit 0 of the computed address
    w_tgt    = w_is_jalr ? {w_sum_rs[31:1], 1'b0} : w_sum_pc;
    w_actual = w_taken ? w_tgt : (ex_pc + 32'd4);
    w_mis    = w_is_ctl && (w_actual != ex_ppc);
  end

  // ------------------------------------------------------- next-state logic
  always_comb begin
    state_d        = state_q;
    next_invalid_d = next_invalid_q;
    rd_pce_d       = rd_pce_q;
    rd_pc_d        = rd_pc_q;
    bp_we_d        = 1'b0;
    bp_pc_d        = bp_pc_q;
    bp_tkn_d       = bp_tkn_q;
    bp_tgt_d       = bp_tgt_q;
    br_cnt_d       = br_cnt_q;
    mis_cnt_d      = mis_cnt_q;

    // A stall freezes everything; the update strobe is simply not raised.
    if (!stl_mm) begin
      case (state_q)
        IDLE: begin
          if (w_is_ctl) begin
            bp_we_d  = 1'b1;
            bp_pc_d  = ex_pc;
            bp_tkn_d = w_taken;
            bp_tgt_d = w_tgt;
            if (br_cnt_q != {CNT_W{1'b1}}) br_cnt_d = br_cnt_q + 1'b1;
            if (w_mis) begin
              rd_pc_d        = w_actual;
              rd_pce_d       = 1'b1;
              next_invalid_d = 1'b1;
              if (mis_cnt_q != {CNT_W{1'b1}}) mis_cnt_d = mis_cnt_q + 1'b1;
              state_d        = REDIR;
            end
          end
        end
        REDIR: begin
          // EX holds wrong-path work here; only the ack matters.
          if (rd_ack) begin
            rd_pce_d       = 1'b0;
            next_invalid_d = 1'b0;
            state_d        = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      next_invalid_q <= 1'b0;
      rd_pce_q       <= 1'b0;
      rd_pc_q        <= 32'd0;
      bp_we_q        <= 1'b0;
      bp_pc_q        <= 32'd0;
      bp_tkn_q       <= 1'b0;
      bp_tgt_q       <= 32'd0;
      br_cnt_q       <= '0;
      mis_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      next_invalid_q <= next_invalid_d;
      rd_pce_q       <= rd_pce_d;
      rd_pc_q        <= rd_pc_d;
      bp_we_q        <= bp_we_d;
      bp_pc_q        <= bp_pc_d;
      bp_tkn_q       <= bp_tkn_d;
      bp_tgt_q       <= bp_tgt_d;
      br_cnt_q       <= br_cnt_d;
      mis_cnt_q      <= mis_cnt_d;
    end
  end

  assign next_invalid = next_invalid_q;
  assign rd_pce       = rd_pce_q;
  assign rd_pc        = rd_pc_q;
  assign bp_we        = bp_we_q;
  assign bp_pc        = bp_pc_q;
  assign bp_tkn       = bp_tkn_q;
  assign bp_tgt       = bp_tgt_q;
  assign br_cnt       = br_cnt_q;
  assign mis_cnt      = mis_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_redirect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_redirect
//  Purpose  : Self-checking bench for ex_redirect (4-bit counters so that
//             saturation is reachable): directed vector table, hand-written
//             reset / saturation sequences and a randomized run against a
//             behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ex_redirect;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [6:0]       ex_t;
  logic [2:0]       ex_st;
  logic [31:0]      ex_n1, ex_n2, ex_nn, ex_pc, ex_ppc;
  logic             stl_mm, rd_ack;
  logic             next_invalid, rd_pce, bp_we, bp_tkn;
  logic [31:0]      rd_pc, bp_pc, bp_tgt;
  logic [CNT_W-1:0] br_cnt, mis_cnt;

  int checks   = 0;
  int failures = 0;

  ex_redirect #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ex_t(ex_t), .ex_st(ex_st), .ex_n1(ex_n1), .ex_n2(ex_n2),
    .ex_nn(ex_nn), .ex_pc(ex_pc), .ex_ppc(ex_ppc),
    .stl_mm(stl_mm), .rd_ack(rd_ack),
    .next_invalid(next_invalid), .rd_pce(rd_pce), .rd_pc(rd_pc),
    .bp_we(bp_we), .bp_pc(bp_pc), .bp_tkn(bp_tkn), .bp_tgt(bp_tgt),
    .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] t, input logic [2:0] st,
                       input logic [31:0] n1, input logic [31:0] n2,
                       input logic [31:0] nn, input logic [31:0] pc,
                       input logic [31:0] ppc, input logic ack, input logic stl);
    ex_t = t; ex_st = st; ex_n1 = n1; ex_n2 = n2; ex_nn = nn;
    ex_pc = pc; ex_ppc = ppc; rd_ack = ack; stl_mm = stl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(7'h0, 3'd0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b1;
  endtask

  // -------------------------------------------------- reference model
  bit          m_redir;
  bit          m_pce, m_ni, m_we, m_tkn;
  logic [31:0] m_rdpc, m_bppc, m_tgt;
  int          m_br, m_mis;

  task automatic model_clear();
    m_redir = 0; m_pce = 0; m_ni = 0; m_we = 0; m_tkn = 0;
    m_rdpc = 0; m_bppc = 0; m_tgt = 0; m_br = 0; m_mis = 0;
  endtask

  // What the instruction in EX actually does, straight from the ISA rules.
  task automatic resolve(output bit ctl, output bit tkn,
                         output logic [31:0] tgt, output logic [31:0] nxt);
    longint s1, s2;
    s1 = longint'($signed(ex_n1));
    s2 = longint'($signed(ex_n2));
    ctl = 0; tkn = 0;
    tgt = ex_pc + ex_nn;
    if (ex_t == 7'h6F) begin
      ctl = 1; tkn = 1;
    end else if (ex_t == 7'h67) begin
      ctl = 1; tkn = 1;
      tgt = ((ex_n1 + ex_nn) >> 1) << 1;
    end else if (ex_t == 7'h63) begin
      ctl = 1;
      case (ex_st)
        3'd0: tkn = (ex_n1 == ex_n2);
        3'd1: tkn = (ex_n1 != ex_n2);
        3'd4: tkn = (s1 < s2);
        3'd5: tkn = !(s1 < s2);
        3'd6: tkn = (longint'(ex_n1) < longint'(ex_n2));
        3'd7: tkn = !(longint'(ex_n1) < longint'(ex_n2));
        default: ctl = 0;
      endcase
    end
    nxt = tkn ? tgt : ex_pc + 32'd4;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_edge();
    bit ctl, tkn;
    logic [31:0] tgt, nxt;
    resolve(ctl, tkn, tgt, nxt);
    m_we = 0;
    if (!stl_mm) begin
      if (!m_redir) begin
        if (ctl) begin
          m_we = 1; m_bppc = ex_pc; m_tkn = tkn; m_tgt = tgt;
          m_br = (m_br + 1 > CMAX) ? CMAX : m_br + 1;
          if (nxt != ex_ppc) begin
            m_redir = 1; m_pce = 1; m_ni = 1; m_rdpc = nxt;
            m_mis = (m_mis + 1 > CMAX) ? CMAX : m_mis + 1;
          end
        end
      end else if (rd_ack) begin
        m_redir = 0; m_pce = 0; m_ni = 0;
      end
    end
  endtask

  task automatic model_compare();
    chk("rnd_rd_pce", 32'(rd_pce), 32'(m_pce));
    chk("rnd_next_invalid", 32'(next_invalid), 32'(m_ni));
    chk("rnd_rd_pc", rd_pc, m_rdpc);
    chk("rnd_bp_we", 32'(bp_we), 32'(m_we));
    chk("rnd_bp_pc", bp_pc, m_bppc);
    chk("rnd_bp_tkn", 32'(bp_tkn), 32'(m_tkn));
    chk("rnd_bp_tgt", bp_tgt, m_tgt);
    chk("rnd_br_cnt", 32'(br_cnt), 32'(m_br));
    chk("rnd_mis_cnt", 32'(mis_cnt), 32'(m_mis));
  endtask

  // -------------------------------------------------- directed table
  typedef struct {
    logic [6:0]  t;
    logic [2:0]  st;
    logic [31:0] n1, n2, nn, pc, ppc;
    logic        ack, stl;
    logic        e_pce;
    logic [31:0] e_rdpc;
    logic        e_ni, e_we, e_tkn;
    logic [31:0] e_tgt;
    int          e_br, e_mis;
  } vec_t;

  vec_t vt[20];

  initial begin
    // t, st, n1, n2, nn, pc, ppc, ack, stl | pce, rdpc, ni, we, tkn, tgt, br, mis
    vt[0]  = '{7'h63, 3'd0, 32'd5, 32'd5, 32'h20, 32'h100, 32'h104, 1'b0, 1'b0, 1'b1, 32'h120, 1'b1, 1'b1, 1'b1, 32'h120, 1, 1};
    vt[1]  = '{7'h00, 3'd0, 32'd0, 32'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h120, 1'b1, 1'b0, 1'b1, 32'h120, 1, 1};
    vt[2]  = vt[1];
    vt[3]  = vt[1];
    // wrong-path BNE on the ack edge must not resolve
    vt[4]  = '{7'h63, 3'd1, 32'd1, 32'd2, 32'h10, 32'h800, 32'h804, 1'b1, 1'b0, 1'b0, 32'h120, 1'b0, 1'b0, 1'b1, 32'h120, 1, 1};
    vt[5]  = '{7'h63, 3'd4, 32'hFFFFFFFF, 32'd1, 32'h40, 32'h200, 32'h240, 1'b0, 1'b0, 1'b0, 32'h120, 1'b0, 1'b1, 1'b1, 32'h240, 2, 1};
    vt[6]  = '{7'h63, 3'd6, 32'hFFFFFFFF, 32'd1, 32'h40, 32'h200, 32'h204, 1'b0, 1'b0, 1'b0, 32'h120, 1'b0, 1'b1, 1'b0, 32'h240, 3, 1};
    vt[7]  = '{7'h67, 3'd0, 32'h1001, 32'd0, 32'h4, 32'h300, 32'h1004, 1'b0, 1'b0, 1'b0, 32'h120, 1'b0, 1'b1, 1'b1, 32'h1004, 4, 1};
    vt[8]  = '{7'h67, 3'd0, 32'h1001, 32'd0, 32'h4, 32'h300, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1004, 1'b1, 1'b1, 1'b1, 32'h1004, 5, 2};
    // ack under stall is not sampled
    vt[9]  = '{7'h00, 3'd0, 32'd0, 32'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h1004, 1'b1, 1'b0, 1'b1, 32'h1004, 5, 2};
    vt[10] = '{7'h00, 3'd0, 32'd0, 32'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h1004, 1'b0, 1'b0, 1'b1, 32'h1004, 5, 2};
    // funct3 010 is not a branch; ack in IDLE is ignored
    vt[11] = '{7'h63, 3'd2, 32'd5, 32'd5, 32'h20, 32'h100, 32'h0, 1'b1, 1'b0, 1'b0, 32'h1004, 1'b0, 1'b0, 1'b1, 32'h1004, 5, 2};
    vt[12] = '{7'h63, 3'd1, 32'd1, 32'd2, 32'h10, 32'h400, 32'h404, 1'b0, 1'b1, 1'b0, 32'h1004, 1'b0, 1'b0, 1'b1, 32'h1004, 5, 2};
    vt[13] = vt[12];
    vt[14] = '{7'h63, 3'd1, 32'd1, 32'd2, 32'h10, 32'h400, 32'h404, 1'b0, 1'b0, 1'b1, 32'h410, 1'b1, 1'b1, 1'b1, 32'h410, 6, 3};
    // ack accepted in the first REDIR cycle
    vt[15] = '{7'h00, 3'd0, 32'd0, 32'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h410, 1'b0, 1'b0, 1'b1, 32'h410, 6, 3};
    vt[16] = '{7'h6F, 3'd0, 32'd0, 32'd0, 32'h100, 32'h500, 32'h600, 1'b0, 1'b0, 1'b0, 32'h410, 1'b0, 1'b1, 1'b1, 32'h600, 7, 3};
    vt[17] = '{7'h63, 3'd5, 32'hFFFFFFFF, 32'd1, 32'h8, 32'h700, 32'h708, 1'b0, 1'b0, 1'b1, 32'h704, 1'b1, 1'b1, 1'b0, 32'h708, 8, 4};
    vt[18] = '{7'h00, 3'd0, 32'd0, 32'd0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h704, 1'b0, 1'b0, 1'b0, 32'h708, 8, 4};
    vt[19] = '{7'h63, 3'd7, 32'hFFFFFFFF, 32'd1, 32'h8, 32'h700, 32'h708, 1'b0, 1'b0, 1'b0, 32'h704, 1'b0, 1'b1, 1'b1, 32'h708, 9, 4};
  end

  // -------------------------------------------------- main sequence
  initial begin
    rst = 1'b0;
    drive(7'h0, 3'd0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    #1;
    do_reset();

    chk("reset_rd_pce", 32'(rd_pce), 0);
    chk("reset_next_invalid", 32'(next_invalid), 0);
    chk("reset_rd_pc", rd_pc, 0);
    chk("reset_bp_we", 32'(bp_we), 0);
    chk("reset_bp_pc", bp_pc, 0);
    chk("reset_bp_tkn", 32'(bp_tkn), 0);
    chk("reset_bp_tgt", bp_tgt, 0);
    chk("reset_br_cnt", 32'(br_cnt), 0);
    chk("reset_mis_cnt", 32'(mis_cnt), 0);

    for (int i = 0; i < 20; i++) begin
      drive(vt[i].t, vt[i].st, vt[i].n1, vt[i].n2, vt[i].nn, vt[i].pc,
            vt[i].ppc, vt[i].ack, vt[i].stl);
      tick();
      chk($sformatf("vec%0d_rd_pce", i), 32'(rd_pce), 32'(vt[i].e_pce));
      chk($sformatf("vec%0d_rd_pc", i), rd_pc, vt[i].e_rdpc);
      chk($sformatf("vec%0d_next_invalid", i), 32'(next_invalid), 32'(vt[i].e_ni));
      chk($sformatf("vec%0d_bp_we", i), 32'(bp_we), 32'(vt[i].e_we));
      chk($sformatf("vec%0d_bp_tkn", i), 32'(bp_tkn), 32'(vt[i].e_tkn));
      chk($sformatf("vec%0d_bp_tgt", i), bp_tgt, vt[i].e_tgt);
      chk($sformatf("vec%0d_br_cnt", i), 32'(br_cnt), 32'(vt[i].e_br));
      chk($sformatf("vec%0d_mis_cnt", i), 32'(mis_cnt), 32'(vt[i].e_mis));
    end

    // ---- asynchronous reset in the middle of REDIR
    drive(7'h63, 3'd0, 32'd7, 32'd7, 32'h40, 32'h900, 32'h904, 1'b0, 1'b0);
    tick();
    chk("arst_pre_rd_pce", 32'(rd_pce), 1);
    drive(7'h0, 3'd0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_rd_pce", 32'(rd_pce), 0);
    chk("arst_next_invalid", 32'(next_invalid), 0);
    chk("arst_br_cnt", 32'(br_cnt), 0);
    chk("arst_mis_cnt", 32'(mis_cnt), 0);
    tick();
    rst = 1'b1;
    drive(7'h6F, 3'd0, 0, 0, 32'h20, 32'hA00, 32'hA20, 1'b1, 1'b0);
    tick();
    chk("arst_jal_br_cnt", 32'(br_cnt), 1);
    chk("arst_jal_rd_pce", 32'(rd_pce), 0);
    chk("arst_jal_mis_cnt", 32'(mis_cnt), 0);

    // ---- saturation: 20 mispredicts with prompt acks
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(7'h63, 3'd0, 32'd3, 32'd3, 32'h80, 32'h1000, 32'h1004, 1'b0, 1'b0);
      tick();
      drive(7'h0, 3'd0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
      tick();
    end
    chk("sat_mis_cnt", 32'(mis_cnt), 15);
    chk("sat_br_cnt", 32'(br_cnt), 15);
    chk("sat_rd_pce", 32'(rd_pce), 0);
    drive(7'h63, 3'd2, 32'd3, 32'd3, 32'h80, 32'h1000, 32'h0, 1'b0, 1'b0);
    tick();
    chk("f3_010_bp_we", 32'(bp_we), 0);
    chk("f3_010_rd_pce", 32'(rd_pce), 0);

    // ---- randomized run against the reference model
    do_reset();
    model_clear();
    for (int i = 0; i < 600; i++) begin
      bit ctl, tkn;
      logic [31:0] tgt, nxt;
      int k;
      k = $urandom_range(0, 9);
      ex_t   = (k < 4) ? 7'h63 : (k < 6) ? 7'h6F : (k < 8) ? 7'h67 : (k < 9) ? 7'h00 : 7'h13;
      ex_st  = 3'($urandom_range(0, 7));
      ex_n1  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3)) - 32'd1;
      ex_n2  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 3)) - 32'd1;
      ex_nn  = 32'($signed(12'($urandom)));
      ex_pc  = $urandom & 32'hFFFF_FFFC;
      resolve(ctl, tkn, tgt, nxt);
      ex_ppc = ($urandom_range(0, 1) == 0) ? nxt : (ex_pc + 32'd4);
      stl_mm = ($urandom_range(0, 4) == 0);
      rd_ack = ($urandom_range(0, 2) == 0);
      model_edge();
      tick();
      model_compare();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_redirect.md
# ex_redirect

EX-stage control-transfer resolver and front-end redirect controller. Consumes the decoded instruction held in the ID/EX register (`ex_*` fields) and resolves conditional branches, JAL and JALR. It compares the real next PC against the predicted next PC `ex_ppc`. On a mispredict it drives `next_invalid` back into the ID/EX register and holds a redirect PC to IF until IF acknowledges it. It also issues predictor-update pulses and keeps resolved/mispredict counters.

## Interface

Parameters:
- `CNT_W`, default 16: width of the saturating statistics counters.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-low; all state cleared while low.
- `ex_t`  in  7  opcode. 7'h63 = B, 7'h6F = JAL, 7'h67 = JALR, 7'h0 = bubble.
- `ex_st`  in  3  funct3.
- `ex_n1`, `ex_n2`  in  32  rs1/rs2 operand values.
- `ex_nn`  in  32  sign-extended immediate.
- `ex_pc`  in  32  instruction PC.
- `ex_ppc`  in  32  predicted next PC.
- `stl_mm`  in  1  memory stall; freezes this block.
- `rd_ack`  in  1  IF has accepted `rd_pc`.
- `next_invalid`  out  1  flush request to ID/EX.
- `rd_pce`  out  1  redirect valid.
- `rd_pc`  out  32  redirect target.
- `bp_we`  out  1  predictor update strobe.
- `bp_pc`  out  32  PC of the resolved instruction.
- `bp_tkn`  out  1  resolved direction.
- `bp_tgt`  out  32  computed target.
- `br_cnt`  out  CNT_W  resolved control transfers, saturating.
- `mis_cnt`  out  CNT_W  mispredicts, saturating.

## Operation

Combinational resolve:
- `is_ctl` = B with funct3 in {000,001,100,101,110,111}, or JAL, or JALR. B with funct3 010 or 011 is not a control transfer.
- Branch taken conditions:
  - 000 beq: n1 == n2
  - 001 bne: n1 != n2
  - 100 blt: signed n1 < n2
  - 101 bge: signed n1 >= n2
  - 110 bltu: unsigned n1 < n2
  - 111 bgeu: unsigned n1 >= n2
- JAL and JALR are always taken.
- Target:
  - B and JAL: `ex_pc + ex_nn`, mod 2^32.
  - JALR: `(ex_n1 + ex_nn) & ~1`, mod 2^32.
- Actual next PC = taken ? target : `ex_pc + 4`, wrapping mod 2^32.
- `mis` = `is_ctl` && (actual != `ex_ppc`).

FSM states: IDLE, REDIR.
- IDLE, `stl_mm`=0, `is_ctl`=1:
  - `bp_we`<=1; `bp_pc`/`bp_tkn`/`bp_tgt` <= `ex_pc`/taken/target.
  - `br_cnt`++.
  - If `mis`: `rd_pc`<=actual, `rd_pce`<=1, `next_invalid`<=1, `mis_cnt`++, go to REDIR.
- IDLE, any other case: `bp_we`<=0; all other outputs hold.
- REDIR:
  - `ex_*` inputs are ignored (wrong path).
  - `rd_pc`, `rd_pce` and `next_invalid` are held.
  - `rd_ack`=1 with `stl_mm`=0: `rd_pce`<=0, `next_invalid`<=0, go to IDLE.
- `stl_mm`=1 in any state:
  - FSM, counters and redirect outputs freeze.
  - `rd_ack` is not sampled.
  - `bp_we`<=0.
- Counters saturate at all-ones and never wrap.
- Bubble (`ex_t`=0) or non-control opcode: no update, no counting.

## Timing

- Reset values: `next_invalid`=0, `rd_pce`=0, `rd_pc`=0, `bp_we`=0, `bp_pc`=0, `bp_tkn`=0, `bp_tgt`=0, `br_cnt`=0, `mis_cnt`=0, state IDLE.
- Latency: an instruction in EX during cycle N (unstalled) produces `bp_*`, `rd_*` and `next_invalid` in cycle N+1. Registered outputs; no combinational path from `ex_*` to any output.
- `bp_we` is high for exactly one cycle per resolved instruction.
- A held-stalled instruction resolves once, in the first cycle with `stl_mm`=0.
- The redirect handshake is level-based:
  - `rd_pce` stays high until the first posedge with `rd_ack`=1 and `stl_mm`=0.
  - `rd_pce` drops in the following cycle.
  - Minimum REDIR residency is 1 cycle; `rd_ack` in the first REDIR cycle is accepted.
- `rd_ack` is ignored in IDLE.
- Mispredict back-to-back with the ack edge: the instruction in EX on the ack edge is wrong-path and is not resolved.
- Reset asserted mid-REDIR: outputs clear immediately (asynchronous); no pending redirect survives.

## Test plan

- **BEQ mispredict:** `ex_t`=63, `ex_st`=0, n1=n2=5, pc=0x100, nn=0x20, ppc=0x104 -> next cycle `rd_pce`=1, `rd_pc`=0x120, `next_invalid`=1, `bp_we`=1, `bp_tkn`=1, `bp_tgt`=0x120, `mis_cnt`=1. Delay `rd_ack` 3 cycles -> outputs held throughout, then cleared the cycle after ack.
- **Signed/unsigned split:** n1=0xFFFFFFFF, n2=1, pc=0x200, nn=0x40. BLT with ppc=0x240 -> taken, no redirect. BLTU with ppc=0x204 -> not taken, no redirect. Result: `br_cnt`=2, `mis_cnt`=0.
- **JALR bit clear:** n1=0x1001, nn=4. ppc=0x1004 -> no redirect, `bp_tgt`=0x1004. ppc=0 -> `rd_pc`=0x1004.
- **Stall:** BNE mispredict presented with `stl_mm`=1 for 2 cycles -> no output change. It resolves the cycle after `stl_mm` falls. In REDIR, `rd_ack`=1 with `stl_mm`=1 -> stays in REDIR.
- **Reset:** `rst` low during REDIR -> `rd_pce`, `next_invalid` and counters 0 immediately. After release, a JAL with correct ppc -> `br_cnt`=1.
- **Saturation:** `CNT_W`=4, 20 mispredicts with prompt acks -> `mis_cnt`=15, `br_cnt`=15. Funct3=010 branch -> no count.
